cp0_unit: RTL and testbench

Coprocessor 0 for the P7 pipelined MIPS CPU. Sits at the M stage and consumes the ExcCode/bd/PC stream that the D/E/M pipeline registers carry forward. Decides whether an exception or interrupt is taken and drives Req back to every pipeline register to flush them. Holds SR/Cause/EPC/PRId, serves mfc0/mtc0, and clears EXL on eret.

---
 rtl/cp0_pkg.sv | 56 +++++
 rtl/cp0_timer.sv | 34 +++
 rtl/cp0_unit.sv | 100 ++++++++++
 tb/tb_cp0_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCodes and
// packed views of the SR/Cause state plus helpers that expand them to 32 bits.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IM_LO     = 10;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc;
  } cause_t;

  function automatic logic [31:0] sr_word(sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_LO +: 6] = s.im;
    w[SR_EXL]        = s.exl;
    w[SR_IE]         = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD]           = c.bd;
    w[CAUSE_IP_LO +: 6]   = c.ip;
    w[CAUSE_EXC_LO +: 5]  = c.exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky TI flag; only instantiated when
// CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      ti      <= 1'b0;
    end else begin
      // a software load of Count overrides the free-running increment
      if (wr_en && wr_addr == CP0_COUNT) count <= wr_data;
      else                               count <= count + 32'd1;
      if (wr_en && wr_addr == CP0_COMPARE) begin
        compare <= wr_data;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: exception/interrupt decision (Req), SR/Cause/
// EPC/PRId, mfc0/mtc0 and eret. Optional timer via macro CP0_TIMER_EN.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h2021_0007,
  parameter int          HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          A1,
  input  logic [4:0]          A2,
  input  logic [31:0]         Din,
  input  logic                we,
  input  logic [31:0]         pc_M,
  input  logic                bd_in,
  input  logic [4:0]          ExcCode_in,
  input  logic [HW_INT_W-1:0] HWInt,
  input  logic                eret,
  output logic                Req,
  output logic [31:0]         EPC,
  output logic [31:0]         Dout
);

  sr_t           sr;
  cause_t        cause;
  logic [31:0]   epc;
  logic [5:0]    hw_eff;
  logic          int_req;
  logic          exc_req;
  logic          mtc0;

  assign mtc0 = we & ~Req;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        ti;

  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mtc0),
    .wr_addr (A2),
    .wr_data (Din),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  assign hw_eff = HWInt | {ti, 5'b0};
`else
  assign hw_eff = HWInt;
`endif

  assign int_req = (|(hw_eff & sr.im)) & sr.ie & ~sr.exl;
  assign exc_req = (ExcCode_in != EXC_INT) & ~sr.exl;
  assign Req     = int_req | exc_req;
  assign EPC     = epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      cause <= '0;
      epc   <= '0;
    end else begin
      cause.ip <= hw_eff;
      if (Req) begin
        sr.exl    <= 1'b1;
        cause.exc <= int_req ? EXC_INT : ExcCode_in;
        cause.bd  <= bd_in;
        epc       <= bd_in ? pc_M - 32'd4 : pc_M;
      end else begin
        if (mtc0 && A2 == CP0_SR) begin
          sr.im  <= Din[SR_IM_LO +: 6];
          sr.exl <= Din[SR_EXL];
          sr.ie  <= Din[SR_IE];
        end
        if (mtc0 && A2 == CP0_EPC) epc <= {Din[31:2], 2'b00};
        // placed after the SR write so eret wins over a same-cycle mtc0 SR
        if (eret) sr.exl <= 1'b0;
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (A1)
      CP0_SR:      Dout = sr_word(sr);
      CP0_CAUSE:   Dout = cause_word(cause);
      CP0_EPC:     Dout = epc;
      CP0_PRID:    Dout = PRID;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   Dout = count;
      CP0_COMPARE: Dout = compare;
`endif
      default:     Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector scoreboard bench for cp0_unit: stimulus pushes expected
// values tagged with a cycle number, a negedge monitor pops and compares.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] Din, pc_M;
  logic        we, bd_in, eret;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPC, Dout;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .we(we),
    .pc_M(pc_M), .bd_in(bd_in), .ExcCode_in(ExcCode_in), .HWInt(HWInt),
    .eret(eret), .Req(Req), .EPC(EPC), .Dout(Dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 Req, 1 Dout, 2 EPC
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    logic [31:0] act;
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      n_vec++;
      case (e.kind)
        0:       act = {31'd0, Req};
        1:       act = Dout;
        default: act = EPC;
      endcase
      if (e.cyc != cyc_cnt) begin
        n_err++;
        $display("FAIL %s: entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc_cnt);
      end else if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, act, e.v);
      end
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc_cnt; e.kind = kind; e.v = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    we = 1'b0; eret = 1'b0; ExcCode_in = 5'd0; bd_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; Din = '0; we = 1'b0; pc_M = '0;
    bd_in = 1'b0; eret = 1'b0; ExcCode_in = 5'd0; HWInt = 6'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    A1 = 5'd12; expect_v(1, 32'h0, "rst_sr"); expect_v(0, 0, "rst_req"); tick();
    A1 = 5'd13; expect_v(1, 32'h0, "rst_cause"); tick();
    A1 = 5'd14; expect_v(1, 32'h0, "rst_epc"); tick();
    A1 = 5'd15; HWInt = 6'h3F;
    expect_v(1, 32'h2021_0007, "prid"); expect_v(0, 0, "req_ie_off"); tick();
    A1 = 5'd13; expect_v(1, 32'h0000_FC00, "cause_ip"); tick();
    HWInt = 6'h00;

    // interrupt
    we = 1; A2 = 5'd12; Din = 32'h0000_0401; expect_v(0, 0, "mtc0_sr_noreq"); tick();
    HWInt = 6'h01; pc_M = 32'h0000_1000; expect_v(0, 1, "int_req"); tick();
    A1 = 5'd12; expect_v(0, 0, "int_exl_blocks"); expect_v(1, 32'h0000_0403, "int_sr"); tick();
    A1 = 5'd13; expect_v(1, 32'h0000_0400, "int_cause"); expect_v(2, 32'h0000_1000, "int_epc"); tick();
    HWInt = 6'h00; eret = 1; expect_v(0, 0, "eret_noreq"); tick();

    // exception in delay slot
    ExcCode_in = 5'd12; bd_in = 1; pc_M = 32'h0000_3010; expect_v(0, 1, "ov_req"); tick();
    A1 = 5'd13; expect_v(1, 32'h8000_0030, "ov_cause"); expect_v(2, 32'h0000_300C, "ov_epc"); tick();
    A1 = 5'd14; expect_v(1, 32'h0000_300C, "ov_dout_epc"); tick();

    // EXL masks exceptions, eret re-enables
    ExcCode_in = 5'd4; expect_v(0, 0, "exl_masks_exc"); tick();
    A1 = 5'd13; expect_v(1, 32'h8000_0030, "cause_held"); tick();
    eret = 1; tick();
    ExcCode_in = 5'd4; pc_M = 32'h0000_2000; expect_v(0, 1, "adel_after_eret"); tick();
    eret = 1; A1 = 5'd13; expect_v(1, 32'h0000_0010, "adel_cause"); tick();

    // Req discards same-cycle mtc0 EPC
    ExcCode_in = 5'd5; pc_M = 32'h0000_4000; we = 1; A2 = 5'd14; Din = 32'h1234_5678;
    expect_v(0, 1, "ades_req"); tick();
    A1 = 5'd13; expect_v(2, 32'h0000_4000, "mtc0_discarded"); expect_v(1, 32'h0000_0014, "ades_cause"); tick();

    // eret with Req: Req wins
    eret = 1; tick();
    eret = 1; ExcCode_in = 5'd8; pc_M = 32'h0000_5000; expect_v(0, 1, "sys_req_eret"); tick();
    A1 = 5'd12; expect_v(1, 32'h0000_0403, "req_beats_eret"); tick();

    // mtc0 EPC low bits, mtc0 Cause ignored, mtc0 SR + eret
    we = 1; A2 = 5'd14; Din = 32'h1234_5677; tick();
    we = 1; A2 = 5'd13; Din = 32'hFFFF_FFFF; expect_v(2, 32'h1234_5674, "epc_align"); tick();
    we = 1; A2 = 5'd12; Din = 32'h0000_0403; eret = 1;
    A1 = 5'd13; expect_v(1, 32'h0000_0020, "cause_ro"); tick();
    A1 = 5'd12; expect_v(1, 32'h0000_0401, "eret_after_mtc0"); tick();
    A1 = 5'd3; expect_v(1, 32'h0, "dout_unmapped"); tick();

    // reset while EXL=1
    ExcCode_in = 5'd10; expect_v(0, 1, "ri_req"); tick();
    reset = 1; tick();
    reset = 0; A1 = 5'd12; ExcCode_in = 5'd0;
    expect_v(1, 32'h0, "rst_exl_sr"); expect_v(2, 32'h0, "rst_exl_epc"); tick();

`ifdef CP0_TIMER_EN
    we = 1; A2 = 5'd11; Din = 32'd5; tick();
    we = 1; A2 = 5'd9;  Din = 32'd0; tick();
    we = 1; A2 = 5'd12; Din = 32'h0000_8001; tick();
    repeat (4) begin expect_v(0, 0, "tmr_wait"); tick(); end
    A1 = 5'd9; expect_v(1, 32'd5, "tmr_count5"); expect_v(0, 0, "tmr_eq_cycle"); tick();
    expect_v(0, 1, "tmr_req"); tick();
    A1 = 5'd13; expect_v(1, 32'h0000_8000, "tmr_cause"); we = 1; A2 = 5'd11; Din = 32'd100; tick();
    eret = 1; tick();
    A1 = 5'd11; expect_v(1, 32'd100, "tmr_compare"); expect_v(0, 0, "tmr_ti_cleared"); tick();
`else
    we = 1; A2 = 5'd9; Din = 32'h0000_0055; tick();
    A1 = 5'd9; expect_v(1, 32'h0, "no_timer_count"); tick();
`endif

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++; n_err++;
      $display("FAIL %s: never checked, want %h", e.name, e.v);
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
